tpu_command_scheduler: RTL and testbench



---
 rtl/tpu_command_scheduler_pkg.sv | 24 ++
 rtl/tpu_command_scheduler_fifo.sv | 54 +++++
 rtl/tpu_command_scheduler.sv | 141 ++++++++++++++
 tb/tb_tpu_command_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_command_scheduler_pkg.sv
// Shared types and constants for the TPU command scheduler and its benches.
package tpu_command_scheduler_pkg;

   localparam int CMD_WIDTH = 48;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CHECK = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   typedef struct packed {
      logic                 last;
      logic [CMD_WIDTH-1:0] command;
   } fifo_entry_t;

   localparam logic [7:0] TPU_CLEARSCREEN = 8'h01;
   localparam logic [7:0] TPU_PRINT       = 8'h02;
   localparam logic [7:0] TPU_LOCATE      = 8'h03;
   localparam logic [7:0] TPU_SETATTR     = 8'h04;
   localparam logic [7:0] TPU_SETMASK     = 8'h05;

endpackage

// File: rtl/tpu_command_scheduler_fifo.sv
// Per-source command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module tpu_cmd_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_s;
   logic             pop_s;

   assign full     = (count_r == DEPTH_C);
   assign empty    = (count_r == (AW+1)'(0));
   assign push_s   = push & ~full;
   assign pop_s    = pop & ~empty;
   assign pop_data = mem_r[rd_ptr_r];

   // Storage array: data only, validity is tracked by the counter.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/tpu_command_scheduler.sv
// Shares the TPU between two command FIFOs with round-robin arbitration and atomic groups.
module tpu_command_scheduler
   import tpu_command_scheduler_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [CMD_WIDTH-1:0] a_command,
   input  logic                 a_last,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [CMD_WIDTH-1:0] b_command,
   input  logic                 b_last,
   output logic                 tpu_execute,
   output logic [CMD_WIDTH-1:0] tpu_command,
   input  logic                 tpu_busy,
   output logic                 idle,
   output logic [7:0]           dropped_count
);
   localparam int          TW         = (LOCK_TIMEOUT > 32'sd1) ? $clog2(LOCK_TIMEOUT + 32'sd1) : 32'sd1;
   localparam logic [TW-1:0] TIMEOUT_C = TW'(LOCK_TIMEOUT);
   localparam bit          TIMEOUT_EN = (LOCK_TIMEOUT != 32'sd0);

   state_t               state_r, state_next_s;
   fifo_entry_t          a_head_s, b_head_s, sel_entry_s;
   logic                 a_full_s, a_empty_s, b_full_s, b_empty_s;
   logic                 sel_valid_s, sel_b_s, pop_a_s, pop_b_s;
   logic                 contested_s, locked_empty_s, timeout_hit_s, lock_eff_s;
   logic                 lock_r, lock_src_r, rr_r, tpu_execute_r;
   logic [CMD_WIDTH-1:0] tpu_command_r;
   logic [7:0]           dropped_r;
   logic [TW-1:0]        lock_cnt_r;

   tpu_cmd_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .reset_n(reset_n), .push(a_valid), .push_data({a_last, a_command}),
      .pop(pop_a_s), .pop_data(a_head_s), .full(a_full_s), .empty(a_empty_s)
   );

   tpu_cmd_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .reset_n(reset_n), .push(b_valid), .push_data({b_last, b_command}),
      .pop(pop_b_s), .pop_data(b_head_s), .full(b_full_s), .empty(b_empty_s)
   );

   assign locked_empty_s = lock_src_r ? b_empty_s : a_empty_s;
   // A stale lock is released in the same idle cycle it expires, so the other port can be granted at once.
   assign timeout_hit_s  = TIMEOUT_EN && lock_r && locked_empty_s &&
                           (state_r == S_IDLE) && (lock_cnt_r == TIMEOUT_C);
   assign lock_eff_s     = lock_r & ~timeout_hit_s;
   assign contested_s    = ~lock_eff_s & ~a_empty_s & ~b_empty_s;
   assign sel_entry_s    = sel_b_s ? b_head_s : a_head_s;
   assign pop_a_s        = sel_valid_s & ~sel_b_s;
   assign pop_b_s        = sel_valid_s & sel_b_s;

   assign a_ready        = ~a_full_s;
   assign b_ready        = ~b_full_s;
   assign idle           = (state_r == S_IDLE) & a_empty_s & b_empty_s & ~lock_r;
   assign tpu_execute    = tpu_execute_r;
   assign tpu_command    = tpu_command_r;
   assign dropped_count  = dropped_r;

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= S_IDLE;
      else          state_r <= state_next_s;
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE:  if (sel_valid_s) state_next_s = S_ISSUE; else state_next_s = S_IDLE;
         S_ISSUE: state_next_s = S_CHECK;
         S_CHECK: if (tpu_busy) state_next_s = S_WAIT; else state_next_s = S_IDLE;
         S_WAIT:  if (tpu_busy) state_next_s = S_WAIT; else state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // FSM output logic: source selection in S_IDLE.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_b_s     = 1'b0;
      if ((state_r == S_IDLE) && !tpu_busy) begin
         if (lock_eff_s) begin
            sel_valid_s = lock_src_r ? ~b_empty_s : ~a_empty_s;
            sel_b_s     = lock_src_r;
         end else if (!a_empty_s && !b_empty_s) begin
            sel_valid_s = 1'b1;
            sel_b_s     = rr_r;
         end else if (!a_empty_s) begin
            sel_valid_s = 1'b1;
            sel_b_s     = 1'b0;
         end else if (!b_empty_s) begin
            sel_valid_s = 1'b1;
            sel_b_s     = 1'b1;
         end else begin
            sel_valid_s = 1'b0;
            sel_b_s     = 1'b0;
         end
      end else begin
         sel_valid_s = 1'b0;
         sel_b_s     = 1'b0;
      end
   end

   // Command register, lock, round-robin pointer, timeout and drop counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tpu_execute_r <= 1'b0;
         tpu_command_r <= {CMD_WIDTH{1'b0}};
         dropped_r     <= 8'd0;
         lock_r        <= 1'b0;
         lock_src_r    <= 1'b0;
         rr_r          <= 1'b0;
         lock_cnt_r    <= TW'(0);
      end else begin
         tpu_execute_r <= (state_next_s == S_ISSUE);
         if (sel_valid_s) begin
            tpu_command_r <= sel_entry_s.command;
            lock_r        <= ~sel_entry_s.last;
            lock_src_r    <= sel_b_s;
         end else if (timeout_hit_s) begin
            lock_r <= 1'b0;
         end
         // Pointer only moves on contended grants, so the loser of a tie wins the next tie.
         if (sel_valid_s && contested_s) rr_r <= ~rr_r;
         if (sel_valid_s || timeout_hit_s || !lock_r) begin
            lock_cnt_r <= TW'(0);
         end else if ((state_r == S_IDLE) && locked_empty_s) begin
            lock_cnt_r <= lock_cnt_r + TW'(1);
         end
         if ((state_r == S_CHECK) && !tpu_busy && (dropped_r != 8'hFF)) begin
            dropped_r <= dropped_r + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_tpu_command_scheduler.sv
// Scoreboard bench: stimulus queues expected TPU commands, a monitor checks each execute pulse.
module tb_tpu_command_scheduler;
   import tpu_command_scheduler_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
   logic [47:0] a_command = 48'h0, b_command = 48'h0;
   logic        a_ready, b_ready, tpu_execute, tpu_busy, idle;
   logic [47:0] tpu_command;
   logic [7:0]  dropped_count;

   int          checks = 0, failures = 0;
   int          busy_len = 2, busy_cnt = 0, cyc = 0;
   int          last_exec = 0, prev_exec = 0;
   logic [47:0] exp_q[$];
   logic [47:0] held_cmd = 48'h0;

   always #5 clk = ~clk;

   tpu_command_scheduler #(.DEPTH(4), .LOCK_TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_command(a_command), .a_last(a_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_command(b_command), .b_last(b_last),
      .tpu_execute(tpu_execute), .tpu_command(tpu_command), .tpu_busy(tpu_busy),
      .idle(idle), .dropped_count(dropped_count)
   );

   // TPU model: busy for busy_len cycles after execute, never busy for opcode 0xFF.
   assign tpu_busy = (busy_cnt != 0);
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_cnt <= 0;
      else if (tpu_execute && tpu_command[7:0] != 8'hFF) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [47:0] mk(input logic [7:0] op, input logic [7:0] p1, input logic [7:0] p2);
      return {24'h0, p2, p1, op};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Monitor: every execute pulse must match the head of the scoreboard; command held while busy.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (tpu_execute) begin
               prev_exec = last_exec;
               last_exec = cyc;
               held_cmd  = tpu_command;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_execute actual=%0h required=none", tpu_command);
               end else begin
                  chk("exec_command", {16'h0, tpu_command}, {16'h0, exp_q.pop_front()});
               end
            end else if (tpu_busy) begin
               chk("command_stable", {16'h0, tpu_command}, {16'h0, held_cmd});
            end
         end
      end
   end

   task automatic push(input logic port_b, input logic [47:0] c, input logic l);
      int n = 0;
      if (port_b) begin b_valid = 1'b1; b_command = c; b_last = l; end
      else        begin a_valid = 1'b1; a_command = c; a_last = l; end
      while (((port_b ? b_ready : a_ready) == 1'b0) && n < 500) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 500) fail_now("push_timeout");
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic push_both(input logic [47:0] ca, input logic [47:0] cb);
      a_valid = 1'b1; a_command = ca; a_last = 1'b1;
      b_valid = 1'b1; b_command = cb; b_last = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || idle !== 1'b1) && n < 3000) begin
         @(negedge clk); n++;
      end
      if (n >= 3000) fail_now(name);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_execute"}, {63'h0, tpu_execute}, 64'h0);
      chk({tag, "_command"}, {16'h0, tpu_command}, 64'h0);
      chk({tag, "_dropped"}, {56'h0, dropped_count}, 64'h0);
      chk({tag, "_a_ready"}, {63'h0, a_ready}, 64'h1);
      chk({tag, "_b_ready"}, {63'h0, b_ready}, 64'h1);
      chk({tag, "_idle"}, {63'h0, idle}, 64'h1);
   endtask

   initial begin
      logic [47:0] c0, c1, c2, c3, c4, bad;
      int n;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single PRINT 'A' from port A.
      c0 = mk(TPU_PRINT, 8'h41, 8'h00);
      chk("print_a_encoding", {16'h0, c0}, 64'h4102);
      exp_q.push_back(c0);
      push(1'b0, c0, 1'b1);
      wait_drain("single_drain_timeout");
      chk("single_idle", {63'h0, idle}, 64'h1);
      chk("single_dropped", {56'h0, dropped_count}, 64'h0);

      // Simultaneous pushes: A wins first tie, B wins the next.
      c0 = mk(TPU_PRINT, 8'h61, 8'h00);
      c1 = mk(TPU_PRINT, 8'h62, 8'h00);
      exp_q.push_back(c0); exp_q.push_back(c1);
      push_both(c0, c1);
      wait_drain("pair1_drain_timeout");
      c2 = mk(TPU_PRINT, 8'h63, 8'h00);
      c3 = mk(TPU_PRINT, 8'h64, 8'h00);
      exp_q.push_back(c3); exp_q.push_back(c2);
      push_both(c2, c3);
      wait_drain("pair2_drain_timeout");

      // Atomic A group interleaved with B pushes.
      c0 = mk(TPU_LOCATE, 8'd5, 8'd3);
      c1 = mk(TPU_SETATTR, 8'h1F, 8'h00);
      c2 = mk(TPU_PRINT, 8'h47, 8'h00);
      c3 = mk(TPU_PRINT, 8'h42, 8'h00);
      c4 = mk(TPU_CLEARSCREEN, 8'h00, 8'h00);
      exp_q.push_back(c0); exp_q.push_back(c1); exp_q.push_back(c2);
      exp_q.push_back(c3); exp_q.push_back(c4);
      push(1'b0, c0, 1'b0);
      push(1'b1, c3, 1'b1);
      push(1'b0, c1, 1'b0);
      push(1'b1, c4, 1'b1);
      push(1'b0, c2, 1'b1);
      wait_drain("group_drain_timeout");

      // Rejected opcode: back in S_IDLE two cycles after execute, count saturates.
      bad = {40'h0, 8'hFF};
      exp_q.push_back(bad);
      push(1'b1, bad, 1'b1);
      n = 0;
      while (tpu_execute !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) fail_now("drop_exec_timeout");
      @(negedge clk);
      chk("drop_check_not_idle", {63'h0, idle}, 64'h0);
      @(negedge clk);
      chk("drop_back_idle", {63'h0, idle}, 64'h1);
      chk("drop_count_1", {56'h0, dropped_count}, 64'd1);
      repeat (299) begin
         exp_q.push_back(bad);
         push(1'b1, bad, 1'b1);
      end
      wait_drain("drop_drain_timeout");
      chk("drop_count_sat", {56'h0, dropped_count}, 64'd255);

      // Dangling lock: B executes 20 cycles after the LOCATE pulse (3 to return idle + 16 + 1).
      busy_len = 1;
      c0 = mk(TPU_LOCATE, 8'd5, 8'd3);
      c1 = mk(TPU_PRINT, 8'h54, 8'h00);
      exp_q.push_back(c0); exp_q.push_back(c1);
      push(1'b0, c0, 1'b0);
      push(1'b1, c1, 1'b1);
      wait_drain("timeout_drain_timeout");
      chk("timeout_gap", 64'(last_exec - prev_exec), 64'd20);
      chk("timeout_idle", {63'h0, idle}, 64'h1);

      // Fill A while the TPU is busy, then reset during S_WAIT.
      busy_len = 1000;
      c0 = mk(TPU_PRINT, 8'h58, 8'h00);
      exp_q.push_back(c0);
      push(1'b0, c0, 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) fail_now("fill_exec_timeout");
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) push(1'b0, mk(TPU_PRINT, 8'h30 + 8'(i), 8'h00), 1'b1);
      chk("fill_a_ready", {63'h0, a_ready}, 64'h0);
      chk("fill_b_ready", {63'h0, b_ready}, 64'h1);
      chk("fill_not_idle", {63'h0, idle}, 64'h0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_values("midreset");
      busy_len = 2;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_reset_idle", {63'h0, idle}, 64'h1);
      c1 = mk(TPU_PRINT, 8'h5A, 8'h00);
      exp_q.push_back(c1);
      push(1'b0, c1, 1'b1);
      wait_drain("post_reset_drain_timeout");
      chk("post_reset_dropped", {56'h0, dropped_count}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
